// File: rtl/uno_ui_pkg.sv
// Shared UI types and overlay geometry for the hand-selection cursor.
package uno_ui_pkg;

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned HAND_W = 5;
  localparam int unsigned PIX_W  = 10;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  // Default overlay geometry and timing.
  localparam int unsigned MAX_CARDS_DEF     = 16;
  localparam int unsigned X_ORIGIN_DEF      = 20;
  localparam int unsigned SLOT_PITCH_DEF    = 36;
  localparam int unsigned Y_ORIGIN_DEF      = 440;
  localparam int unsigned BLINK_FRAMES_DEF  = 15;
  localparam int unsigned REPEAT_FRAMES_DEF = 20;

  typedef logic [IDX_W-1:0] card_idx_t;

  typedef enum logic [1:0] {
    LOCKED,
    BROWSE,
    OFFER,
    RELEASE
  } cursor_state_e;

  // Left edge x of a slot, truncated to the pixel bus width.
  function automatic logic [PIX_W-1:0] slot_x(card_idx_t idx, int unsigned origin,
                                               int unsigned pitch);
    int unsigned x;
    x = origin + 32'(idx) * pitch;
    return x[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/index_cursor_ctrl_if.sv
// Selection handshake between the cursor controller and game logic.
interface index_cursor_ctrl_if;
  import uno_ui_pkg::*;

  logic      sel_valid;
  card_idx_t sel_idx;
  logic      sel_ready;

  modport master (output sel_valid, output sel_idx, input sel_ready);
  modport slave  (input sel_valid, input sel_idx, output sel_ready);
endinterface

// File: rtl/index_cursor_ctrl_key_edge.sv
// Parameterized rising-edge detector; history register updates every cycle.
module key_edge #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] key,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] key_q;

  // Capture previous key levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_q <= '0;
    else     key_q <= key;
  end

  assign rise = key & ~key_q;

endmodule

// File: rtl/index_cursor_ctrl.sv
// Hand-selection cursor: turns debounced keys into a card-slot index, drives the
// highlight overlay and offers the chosen slot over a valid/ready handshake.
// Optional build macro INDEX_CURSOR_AUTOREPEAT_EN adds held-key auto-repeat.
module index_cursor_ctrl
  import uno_ui_pkg::*;
#(
  parameter int unsigned MAX_CARDS     = MAX_CARDS_DEF,
  parameter int unsigned X_ORIGIN      = X_ORIGIN_DEF,
  parameter int unsigned SLOT_PITCH    = SLOT_PITCH_DEF,
  parameter int unsigned Y_ORIGIN      = Y_ORIGIN_DEF,
  parameter int unsigned BLINK_FRAMES  = BLINK_FRAMES_DEF,
  parameter int unsigned REPEAT_FRAMES = REPEAT_FRAMES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                turn_active,
  input  logic [HAND_W-1:0]   hand_size,
  input  logic                key_left,
  input  logic                key_right,
  input  logic                key_sel,
  input  logic                frame_start,
  output logic [PIX_W-1:0]    x_pin,
  output logic [PIX_W-1:0]    y_pin,
  output logic                show,
  output card_idx_t           cursor_idx,
  index_cursor_ctrl_if.master sel
);

  if (X_ORIGIN + (MAX_CARDS - 1) * SLOT_PITCH > SCREEN_W - 1) begin : g_bad_x_geom
    $error("index_cursor_ctrl: last slot x exceeds screen width");
  end
  if (Y_ORIGIN > SCREEN_H - 1) begin : g_bad_y_geom
    $error("index_cursor_ctrl: Y_ORIGIN exceeds screen height");
  end
  if (MAX_CARDS > (1 << IDX_W) || BLINK_FRAMES == 0 || REPEAT_FRAMES == 0) begin : g_bad_cfg
    $error("index_cursor_ctrl: invalid MAX_CARDS/BLINK_FRAMES/REPEAT_FRAMES");
  end

  localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [BW-1:0] BlinkLast = BW'(BLINK_FRAMES - 1);

  cursor_state_e state_q;
  logic [BW-1:0] blink_q;
  logic          sel_valid_q;
  card_idx_t     sel_idx_q;
  card_idx_t     cursor_d;
  card_idx_t     last_idx;
  logic [2:0]    rise;
  logic          left_e, right_e, sel_e;
  logic          hand_zero, shrink, rep_step;
  logic          step_left, step_right;

  key_edge #(.WIDTH(3)) u_key_edge (
    .clk  (clk),
    .rst  (rst),
    .key  ({key_sel, key_right, key_left}),
    .rise (rise)
  );

  assign left_e    = rise[0];
  assign right_e   = rise[1];
  assign sel_e     = rise[2];
  assign hand_zero = (hand_size == '0);
  assign last_idx  = IDX_W'(hand_size - HAND_W'(1));
  // Empty hand is excluded: the cursor is retained and the FSM locks instead.
  assign shrink    = !hand_zero && (hand_size <= HAND_W'(cursor_idx));

  // Opposing edges cancel; a repeat step follows the held direction.
  assign step_left  = (left_e & ~right_e) | (rep_step & key_left);
  assign step_right = (right_e & ~left_e) | (rep_step & key_right);

`ifdef INDEX_CURSOR_AUTOREPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] RepLast = RW'(REPEAT_FRAMES - 1);

  logic [RW-1:0] rep_q;
  logic          one_held, rep_clear;

  assign one_held  = key_left ^ key_right;
  assign rep_clear = (state_q != BROWSE) || !one_held || left_e || right_e;
  assign rep_step  = !rep_clear && frame_start && (rep_q == RepLast);

  // Count frames while a single direction key is held in BROWSE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                rep_q <= '0;
    else if (rep_clear)     rep_q <= '0;
    else if (frame_start)   rep_q <= (rep_q == RepLast) ? '0 : rep_q + RW'(1);
  end
`else
  assign rep_step = 1'b0;
`endif

  // Next cursor: LOCKED entry resets, clamp beats moves, OFFER freezes.
  always_comb begin
    cursor_d = cursor_idx;
    unique case (state_q)
      LOCKED: begin
        if (turn_active && !hand_zero) cursor_d = '0;
        else if (shrink)               cursor_d = last_idx;
      end
      BROWSE: begin
        if (shrink) begin
          cursor_d = last_idx;
        end else if (turn_active && !hand_zero && !sel_e) begin
          if (step_left)       cursor_d = (cursor_idx == '0) ? last_idx : cursor_idx - IDX_W'(1);
          else if (step_right) cursor_d = (cursor_idx == last_idx) ? '0 : cursor_idx + IDX_W'(1);
        end
      end
      RELEASE: begin
        if (shrink) cursor_d = last_idx;
      end
      default: cursor_d = cursor_idx;
    endcase
  end

  // Control FSM with registered overlay and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOCKED;
      cursor_idx  <= '0;
      x_pin       <= PIX_W'(X_ORIGIN);
      y_pin       <= PIX_W'(Y_ORIGIN);
      show        <= 1'b0;
      sel_valid_q <= 1'b0;
      sel_idx_q   <= '0;
      blink_q     <= '0;
    end else begin
      cursor_idx <= cursor_d;
      x_pin      <= slot_x(cursor_d, X_ORIGIN, SLOT_PITCH);
      y_pin      <= PIX_W'(Y_ORIGIN);
      unique case (state_q)
        LOCKED: begin
          show        <= 1'b0;
          sel_valid_q <= 1'b0;
          if (turn_active && !hand_zero) begin
            state_q <= BROWSE;
            show    <= 1'b1;
            blink_q <= '0;
          end
        end
        BROWSE: begin
          if (!turn_active || hand_zero) begin
            state_q     <= LOCKED;
            show        <= 1'b0;
            sel_valid_q <= 1'b0;
          end else if (sel_e) begin
            state_q     <= OFFER;
            show        <= 1'b1;
            sel_valid_q <= 1'b1;
            sel_idx_q   <= cursor_d;
          end else if (frame_start) begin
            if (blink_q == BlinkLast) begin
              blink_q <= '0;
              show    <= ~show;
            end else begin
              blink_q <= blink_q + BW'(1);
            end
          end
        end
        OFFER: begin
          if (!turn_active) begin
            state_q     <= LOCKED;
            show        <= 1'b0;
            sel_valid_q <= 1'b0;
          end else begin
            show <= 1'b1;
            if (sel_valid_q && sel.sel_ready) begin
              sel_valid_q <= 1'b0;
              state_q     <= RELEASE;
            end
          end
        end
        RELEASE: begin
          if (!turn_active || hand_zero) begin
            state_q     <= LOCKED;
            show        <= 1'b0;
            sel_valid_q <= 1'b0;
          end else if (!key_sel) begin
            // Select must be released before another offer can be made.
            state_q <= BROWSE;
            show    <= 1'b1;
            blink_q <= '0;
          end
        end
        default: state_q <= LOCKED;
      endcase
    end
  end

  assign sel.sel_valid = sel_valid_q;
  assign sel.sel_idx   = sel_idx_q;

endmodule

// File: tb/tb_index_cursor_ctrl.sv
// Directed table-driven bench for index_cursor_ctrl.
module tb_index_cursor_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       turn_active = 1'b0;
  logic [4:0] hand_size = '0;
  logic       key_left = 1'b0, key_right = 1'b0, key_sel = 1'b0, frame_start = 1'b0;
  logic [9:0] x_pin, y_pin;
  logic       show;
  logic [3:0] cursor_idx;

  int n_run = 0;
  int n_fail = 0;

  index_cursor_ctrl_if sel_if ();

  index_cursor_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .turn_active (turn_active),
    .hand_size   (hand_size),
    .key_left    (key_left),
    .key_right   (key_right),
    .key_sel     (key_sel),
    .frame_start (frame_start),
    .x_pin       (x_pin),
    .y_pin       (y_pin),
    .show        (show),
    .cursor_idx  (cursor_idx),
    .sel         (sel_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       turn;
    logic [4:0] hs;
    logic       l, r, s, f, rdy;
    logic [3:0] cur;
    logic [9:0] x;
    logic       shw, val;
    logic [3:0] sidx;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic turn, input logic [4:0] hs, input logic l, input logic r,
                     input logic s, input logic f, input logic rdy, input logic [3:0] cur,
                     input logic [9:0] x, input logic shw, input logic val,
                     input logic [3:0] sidx);
    vec_t v;
    v.turn = turn; v.hs = hs; v.l = l; v.r = r; v.s = s; v.f = f; v.rdy = rdy;
    v.cur = cur; v.x = x; v.shw = shw; v.val = val; v.sidx = sidx;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int cur, input int x, input int shw,
                         input int val, input int sidx);
    chk({tag, " cursor_idx"}, int'(cursor_idx), cur);
    chk({tag, " x_pin"}, int'(x_pin), x);
    chk({tag, " y_pin"}, int'(y_pin), 440);
    chk({tag, " show"}, int'(show), shw);
    chk({tag, " sel_valid"}, int'(sel_if.sel_valid), val);
    chk({tag, " sel_idx"}, int'(sel_if.sel_idx), sidx);
  endtask

  initial begin
    sel_if.sel_ready = 1'b0;

    //  turn hs  L R S F rdy  cur  x   show val sidx
    add(1, 5, 0, 0, 0, 0, 0,  0,  20, 1, 0, 0);   // LOCKED -> BROWSE
    add(1, 5, 0, 1, 0, 0, 0,  1,  56, 1, 0, 0);
    add(1, 5, 0, 0, 0, 0, 0,  1,  56, 1, 0, 0);
    add(1, 5, 0, 1, 0, 0, 0,  2,  92, 1, 0, 0);
    add(1, 5, 0, 1, 0, 0, 0,  2,  92, 1, 0, 0);   // held level, no edge
    add(1, 5, 0, 0, 0, 0, 0,  2,  92, 1, 0, 0);
    add(1, 5, 0, 1, 0, 0, 0,  3, 128, 1, 0, 0);
    add(1, 5, 0, 0, 0, 0, 0,  3, 128, 1, 0, 0);
    add(1, 5, 0, 1, 0, 0, 0,  4, 164, 1, 0, 0);
    add(1, 5, 0, 0, 0, 0, 0,  4, 164, 1, 0, 0);
    add(1, 5, 0, 1, 0, 0, 0,  0,  20, 1, 0, 0);   // right wrap
    add(1, 5, 0, 0, 0, 0, 0,  0,  20, 1, 0, 0);
    add(1, 5, 1, 0, 0, 0, 0,  4, 164, 1, 0, 0);   // left wrap
    add(1, 5, 0, 0, 0, 0, 0,  4, 164, 1, 0, 0);
    add(1, 5, 0, 1, 0, 0, 0,  0,  20, 1, 0, 0);
    add(1, 5, 0, 0, 0, 0, 0,  0,  20, 1, 0, 0);
    add(1, 5, 1, 1, 0, 0, 0,  0,  20, 1, 0, 0);   // both edges cancel
    add(1, 5, 0, 0, 0, 0, 0,  0,  20, 1, 0, 0);
    add(1, 5, 0, 1, 0, 0, 0,  1,  56, 1, 0, 0);
    add(1, 5, 0, 0, 0, 0, 0,  1,  56, 1, 0, 0);
    add(1, 5, 0, 1, 0, 0, 0,  2,  92, 1, 0, 0);
    add(1, 5, 0, 0, 0, 0, 0,  2,  92, 1, 0, 0);
    add(1, 5, 0, 1, 1, 0, 0,  2,  92, 1, 1, 2);   // sel beats move
    add(1, 5, 0, 0, 1, 0, 0,  2,  92, 1, 1, 2);
    add(1, 5, 1, 0, 1, 0, 0,  2,  92, 1, 1, 2);   // keys ignored in OFFER
    add(1, 5, 0, 0, 1, 0, 0,  2,  92, 1, 1, 2);
    add(1, 5, 0, 0, 1, 0, 1,  2,  92, 1, 0, 2);   // accepted -> RELEASE
    add(1, 5, 0, 1, 1, 0, 0,  2,  92, 1, 0, 2);
    add(1, 5, 0, 0, 0, 0, 0,  2,  92, 1, 0, 2);   // released -> BROWSE
    add(1, 5, 0, 0, 1, 0, 0,  2,  92, 1, 1, 2);   // new offer
    add(0, 5, 0, 0, 0, 0, 0,  2,  92, 0, 0, 2);   // abort -> LOCKED
    add(1, 3, 0, 0, 0, 0, 0,  0,  20, 1, 0, 2);
    add(1, 5, 1, 0, 0, 0, 0,  4, 164, 1, 0, 2);
    add(1, 5, 0, 0, 0, 0, 0,  4, 164, 1, 0, 2);
    add(1, 2, 0, 0, 0, 0, 0,  1,  56, 1, 0, 2);   // hand shrank -> clamp
    add(1, 0, 0, 0, 0, 0, 0,  1,  56, 0, 0, 2);   // empty hand -> LOCKED
    add(1, 2, 0, 0, 0, 0, 0,  0,  20, 1, 0, 2);

    // Reset state
    #12;
    chk_all("reset", 0, 20, 0, 0, 0);
    rst = 1'b0;
    step();
    chk_all("locked idle", 0, 20, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      turn_active      = vecs[i].turn;
      hand_size        = vecs[i].hs;
      key_left         = vecs[i].l;
      key_right        = vecs[i].r;
      key_sel          = vecs[i].s;
      frame_start      = vecs[i].f;
      sel_if.sel_ready = vecs[i].rdy;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].cur, vecs[i].x, vecs[i].shw, vecs[i].val,
              vecs[i].sidx);
    end
    sel_if.sel_ready = 1'b0;

    // Blink: show toggles on the 15th and 30th frame pulses
    for (int k = 1; k <= 30; k++) begin
      frame_start = 1'b1;
      step();
      chk($sformatf("blink show pulse %0d", k), int'(show), (k < 15) ? 1 : ((k < 30) ? 0 : 1));
      frame_start = 1'b0;
      step();
    end

    // Asynchronous reset during an offer
    key_right = 1'b1;
    step();
    chk("pre-reset move", int'(cursor_idx), 1);
    key_right = 1'b0;
    key_sel = 1'b1;
    step();
    chk("pre-reset offer", int'(sel_if.sel_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async reset", 0, 20, 0, 0, 0);
    key_sel = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Held right key across 40 frames
    hand_size = 5'd5;
    step();
    chk("re-enter idx", int'(cursor_idx), 0);
    key_right = 1'b1;
    step();
    chk("hold edge step", int'(cursor_idx), 1);
    for (int f = 1; f <= 40; f++) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
`ifdef INDEX_CURSOR_AUTOREPEAT_EN
      if (f == 19) chk("repeat f19", int'(cursor_idx), 1);
      if (f == 20) chk("repeat f20", int'(cursor_idx), 2);
      if (f == 39) chk("repeat f39", int'(cursor_idx), 2);
      if (f == 40) chk("repeat f40", int'(cursor_idx), 3);
`else
      if (f == 20 || f == 40) chk($sformatf("no repeat f%0d", f), int'(cursor_idx), 1);
`endif
      step();
    end
    key_right = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
